// File: rtl/edit_reg_block.sv
// Edit register block: four 16-bit edit registers (CYR, SR, CYL, EDOP).
// Each write loads the target after one edit step. A write with a step
// count above 1 keeps stepping the latched target once per cycle while
// BUSY is high. Reads return the register value from before the edge.
module edit_reg_block (
  input  logic        CLK2,
  input  logic        GENRST,
  input  logic [15:0] WRITE_BUS,
  input  logic        WE,
  input  logic [1:0]  WADDR,
  input  logic [3:0]  WCNT,
  input  logic        RE,
  input  logic [1:0]  RADDR,
  output logic [15:0] READ_BUS,
  output logic        RD_VALID,
  output logic        BUSY,
  output logic        WR_ERR
);

  localparam logic [1:0] A_CYR  = 2'd0;
  localparam logic [1:0] A_SR   = 2'd1;
  localparam logic [1:0] A_CYL  = 2'd2;
  localparam logic [1:0] A_EDOP = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_tgt;
  logic        r_busy;
  logic        r_wr_err;
  logic        r_rd_valid;
  logic [15:0] r_read_bus;
  logic [15:0] r_regs [4];

  logic [15:0] w_reg_next [4];
  logic        w_accept;
  logic        w_drop;
  logic [3:0]  w_steps;

  // One edit step on a stored word. The math runs on the 15-bit word
  // {bit15, bits13:0}; bit14 of the result is rebuilt as a copy of bit15,
  // so any bit14 arriving on the write bus is ignored.
  function automatic logic [15:0] edit_step(input logic [1:0] op, input logic [15:0] v);
    logic [14:0] w;
    logic [14:0] n;
    w = {v[15], v[13:0]};
    n = w;
    case (op)
      A_CYR:   n = {w[0], w[14:1]};
      A_SR:    n = {w[14], w[14:1]};
      A_CYL:   n = {w[13:0], w[14]};
      A_EDOP:  n = w >> 7;
      default: n = w;
    endcase
    return {n[14], n[14], n[13:0]};
  endfunction

  assign w_accept = WE && (r_state == S_IDLE);
  assign w_drop   = WE && (r_state == S_SHIFT);

  // Effective step count: 0 behaves as 1, and EDOP always does a single step.
  always_comb begin
    w_steps = WCNT;
    if ((WCNT == 4'd0) || (WADDR == A_EDOP)) begin
      w_steps = 4'd1;
    end
  end

  // Next value per register: a fresh write wins, otherwise a pending step
  // on the latched target, otherwise hold. Writes are never accepted while
  // shifting, so the two cases cannot collide.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
      assign w_reg_next[gi] =
        (w_accept && (WADDR == 2'(gi)))          ? edit_step(2'(gi), WRITE_BUS) :
        ((r_state == S_SHIFT) && (r_tgt == 2'(gi))) ? edit_step(2'(gi), r_regs[gi]) :
                                                    r_regs[gi];
    end
  endgenerate

  // Register file update.
  always_ff @(posedge CLK2) begin
    if (GENRST) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) r_regs[i] <= w_reg_next[i];
    end
  end

  // Edit sequencer: tracks remaining steps, BUSY and the sticky write error.
  always_ff @(posedge CLK2) begin
    if (GENRST) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_tgt    <= 2'd0;
      r_busy   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tgt <= WADDR;
            if (w_steps > 4'd1) begin
              r_state <= S_SHIFT;
              r_cnt   <= w_steps - 4'd1;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          // Counter saturates at 0 rather than wrapping.
          if (r_cnt <= 4'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_drop) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  // Registered read port: captures the pre-edge value, holds when idle.
  always_ff @(posedge CLK2) begin
    if (GENRST) begin
      r_read_bus <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= RE;
      if (RE) begin
        r_read_bus <= r_regs[RADDR];
      end
    end
  end

  assign READ_BUS = r_read_bus;
  assign RD_VALID = r_rd_valid;
  assign BUSY     = r_busy;
  assign WR_ERR   = r_wr_err;

endmodule

// File: tb/tb_edit_reg_block.sv
// Directed testbench for edit_reg_block with hand-computed expectations.
module tb_edit_reg_block;

  logic        CLK2;
  logic        GENRST;
  logic [15:0] WRITE_BUS;
  logic        WE;
  logic [1:0]  WADDR;
  logic [3:0]  WCNT;
  logic        RE;
  logic [1:0]  RADDR;
  logic [15:0] READ_BUS;
  logic        RD_VALID;
  logic        BUSY;
  logic        WR_ERR;

  int checks;
  int errors;

  edit_reg_block dut (
    .CLK2      (CLK2),
    .GENRST    (GENRST),
    .WRITE_BUS (WRITE_BUS),
    .WE        (WE),
    .WADDR     (WADDR),
    .WCNT      (WCNT),
    .RE        (RE),
    .RADDR     (RADDR),
    .READ_BUS  (READ_BUS),
    .RD_VALID  (RD_VALID),
    .BUSY      (BUSY),
    .WR_ERR    (WR_ERR)
  );

  initial CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK2);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d, input logic [3:0] n);
    WE = 1'b1; WADDR = a; WRITE_BUS = d; WCNT = n;
    tick();
    WE = 1'b0;
    $display("write addr=%0d data=%h cnt=%0d busy=%b", a, d, n, BUSY);
  endtask

  task automatic do_read(input string tag, input logic [1:0] a, input logic [15:0] exp);
    RE = 1'b1; RADDR = a;
    tick();
    RE = 1'b0;
    $display("read  addr=%0d data=%h valid=%b", a, READ_BUS, RD_VALID);
    check({tag, "_data"}, READ_BUS, exp);
    check({tag, "_valid"}, 16'(RD_VALID), 16'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    GENRST = 1'b1; WE = 1'b0; RE = 1'b0;
    WRITE_BUS = '0; WADDR = '0; WCNT = '0; RADDR = '0;
    #1;
    tick(); tick();
    GENRST = 1'b0;
    check("rst_read_bus", READ_BUS, 16'h0000);
    check("rst_rd_valid", 16'(RD_VALID), 16'd0);
    check("rst_busy", 16'(BUSY), 16'd0);
    check("rst_wr_err", 16'(WR_ERR), 16'd0);
    for (int i = 0; i < 4; i++) do_read("rst_reg", 2'(i), 16'h0000);

    // Single-step writes to each register.
    do_write(2'd0, 16'h0001, 4'd1);
    check("cyr1_busy", 16'(BUSY), 16'd0);
    do_read("cyr1", 2'd0, 16'hC000);
    tick();
    check("idle_rd_valid", 16'(RD_VALID), 16'd0);
    check("idle_read_hold", READ_BUS, 16'hC000);

    do_write(2'd1, 16'hC004, 4'd1);
    do_read("sr1", 2'd1, 16'hE002);
    do_write(2'd2, 16'h8000, 4'd1);
    do_read("cyl1", 2'd2, 16'h0001);
    do_write(2'd3, 16'h3F80, 4'd5);
    check("edop_busy", 16'(BUSY), 16'd0);
    do_read("edop", 2'd3, 16'h007F);

    // Count 0 behaves as a single step.
    do_write(2'd2, 16'h0001, 4'd0);
    check("cnt0_busy", 16'(BUSY), 16'd0);
    do_read("cyl_cnt0", 2'd2, 16'h0002);

    // Three-step CYR edit, with reads and a dropped write during BUSY.
    do_write(2'd0, 16'h0001, 4'd3);
    check("multi_busy0", 16'(BUSY), 16'd1);
    WE = 1'b1; WADDR = 2'd2; WRITE_BUS = 16'h1234; WCNT = 4'd1;
    RE = 1'b1; RADDR = 2'd0;
    tick();
    WE = 1'b0; RE = 1'b0;
    $display("read  addr=0 data=%h valid=%b (write to CYL while busy)", READ_BUS, RD_VALID);
    check("multi_rd1", READ_BUS, 16'hC000);
    check("multi_busy1", 16'(BUSY), 16'd1);
    check("drop_wr_err", 16'(WR_ERR), 16'd1);
    do_read("multi_rd2", 2'd0, 16'h2000);
    check("multi_busy_end", 16'(BUSY), 16'd0);
    do_read("multi_final", 2'd0, 16'h1000);
    do_read("cyl_unchanged", 2'd2, 16'h0002);
    check("wr_err_sticky", 16'(WR_ERR), 16'd1);

    // Simultaneous write and read to SR returns the old value.
    WE = 1'b1; WADDR = 2'd1; WRITE_BUS = 16'h0008; WCNT = 4'd1;
    RE = 1'b1; RADDR = 2'd1;
    tick();
    WE = 1'b0; RE = 1'b0;
    $display("write+read addr=1 data=%h valid=%b", READ_BUS, RD_VALID);
    check("wr_rd_old", READ_BUS, 16'hE002);
    do_read("wr_rd_new", 2'd1, 16'h0004);

    // Reset one cycle into an eight-step SR edit.
    do_write(2'd1, 16'h8000, 4'd8);
    check("sr8_busy", 16'(BUSY), 16'd1);
    GENRST = 1'b1;
    tick();
    GENRST = 1'b0;
    $display("reset during shift busy=%b wr_err=%b", BUSY, WR_ERR);
    check("abort_busy", 16'(BUSY), 16'd0);
    check("abort_wr_err", 16'(WR_ERR), 16'd0);
    check("abort_read_bus", READ_BUS, 16'h0000);
    check("abort_rd_valid", 16'(RD_VALID), 16'd0);
    tick();
    check("abort_busy_hold", 16'(BUSY), 16'd0);
    for (int i = 0; i < 4; i++) do_read("abort_reg", 2'(i), 16'h0000);

    // Write after reset is accepted: SR 0xC000, two steps.
    do_write(2'd1, 16'hC000, 4'd2);
    check("post_busy", 16'(BUSY), 16'd1);
    tick();
    check("post_busy_end", 16'(BUSY), 16'd0);
    do_read("post_sr", 2'd1, 16'hF000);

    // Reset wins over simultaneous write and read.
    GENRST = 1'b1; WE = 1'b1; WADDR = 2'd0; WRITE_BUS = 16'h0001; WCNT = 4'd1;
    RE = 1'b1; RADDR = 2'd1;
    tick();
    GENRST = 1'b0; WE = 1'b0; RE = 1'b0;
    $display("reset with write+read read_bus=%h valid=%b", READ_BUS, RD_VALID);
    check("rstpri_read_bus", READ_BUS, 16'h0000);
    check("rstpri_rd_valid", 16'(RD_VALID), 16'd0);
    do_read("rstpri_cyr", 2'd0, 16'h0000);
    do_read("rstpri_sr", 2'd1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edit_reg_block.md
EDIT_REG_BLOCK -- requirements
Module: ng_EDR

Interface
REQ-001 SHALL have port CLK2  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port GENRST  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port WRITE_BUS  input  16  write data, same word format as central registers: bit14 is a copy of bit15.
REQ-004 SHALL have port WE  input  1  write strobe, active-high, sampled at rising edge.
REQ-005 SHALL have port WADDR  input  2  write target: 0=CYR, 1=SR, 2=CYL, 3=EDOP.
REQ-006 SHALL have port WCNT  input  4  edit step count for the write; 0 is treated as 1.
REQ-007 SHALL have port RE  input  1  read strobe, active-high.
REQ-008 SHALL have port RADDR  input  2  read target, same encoding as WADDR.
REQ-009 SHALL have port READ_BUS  output  16  registered read data.
REQ-010 SHALL have port RD_VALID  output  1  READ_BUS holds data from the previous cycle's RE.
REQ-011 SHALL have port BUSY  output  1  multi-step edit in progress.
REQ-012 SHALL have port WR_ERR  output  1  sticky flag: a write was dropped while BUSY.

Function
REQ-013 SHALL hold four 16-bit registers CYR, SR, CYL, EDOP; edit math uses 15-bit word W = {bit15, bits13:0}; bit14 of every stored value SHALL equal bit15.
REQ-014 CYR step SHALL rotate W right by 1 (W[0] to W[14]).
REQ-015 SR step SHALL shift W right by 1 arithmetically (W[14] preserved).
REQ-016 CYL step SHALL rotate W left by 1 (W[14] to W[0]).
REQ-017 EDOP step SHALL shift W right by 7 with zero fill; EDOP SHALL always perform exactly one step, regardless of WCNT.
REQ-018 WE at edge k with BUSY low SHALL load the target register with WRITE_BUS after one edit step at edge k.
REQ-019 If effective count N>1, the block SHALL enter state SHIFT and assert BUSY from edge k until edge k+N-1. It SHALL apply one further step per cycle to the latched target only.
REQ-020 The FSM SHALL have states IDLE and SHIFT. IDLE goes to SHIFT on an accepted write with N>1. SHIFT returns to IDLE when the remaining-step counter reaches 0.
REQ-021 WE while BUSY SHALL be dropped, with no register change, and SHALL set WR_ERR; WR_ERR SHALL clear only on reset.
REQ-022 RE at edge k SHALL load READ_BUS with the addressed register's value before edge k updates, and SHALL assert RD_VALID for the cycle after edge k.
REQ-023 When RE is low, RD_VALID SHALL be low and READ_BUS SHALL hold its last value.
REQ-024 A read of a register in SHIFT SHALL be allowed and SHALL return the last completed step value.
REQ-025 Simultaneous WE and RE to the same address SHALL return the old value.
REQ-026 The step counter SHALL be 4 bits and SHALL never wrap.

Reset
REQ-027 GENRST high at a rising edge SHALL clear CYR, SR, CYL, EDOP, READ_BUS, RD_VALID, BUSY and WR_ERR to 0, and SHALL force IDLE.
REQ-028 Reset SHALL take priority over WE and RE in the same cycle.
REQ-029 Reset during SHIFT SHALL abort the edit, leaving the target at 0.

Verification
REQ-030 WE, WADDR=0, WCNT=1, WRITE_BUS=16'h0001, then RE RADDR=0 -> READ_BUS=16'hC000, RD_VALID=1, BUSY never high.
REQ-031 SR write 16'hC004, WCNT=1 -> SR=16'hE002; CYL write 16'h8000 -> CYL=16'h0001; EDOP write 16'h3F80, WCNT=5 -> EDOP=16'h007F, BUSY never high.
REQ-032 CYR write 16'h0001, WCNT=3 -> BUSY high for 2 cycles; reads give 16'hC000 then 16'h2000; final CYR=16'h1000.
REQ-033 WE to CYL during the REQ-032 BUSY window -> CYL unchanged, WR_ERR=1 until reset.
REQ-034 GENRST asserted one cycle into a WCNT=8 SR edit -> next cycle all outputs and registers 0, BUSY=0; a subsequent write is accepted normally.
REQ-035 WE and RE both to SR on the same edge -> READ_BUS shows the pre-write SR value, and the next read shows the new value.
